// File: rtl/fft_rd_pkg.sv
// Shared constants, state encoding and sample helpers for the FFT result RAM reader.
package fft_rd_pkg;

  localparam int unsigned ND_FFT        = 23;
  localparam int unsigned NA_FFT        = 8;
  localparam int unsigned N_DEPTH_FFT   = 1 << NA_FFT;
  localparam int unsigned BYTES_PER_BIN = 6;
  localparam int unsigned SAMPLE_W      = ND_FFT + 1;
  localparam int unsigned WORD_W        = 8 * BYTES_PER_BIN;
  localparam int unsigned CNT_W         = $clog2(BYTES_PER_BIN);

  typedef enum logic [2:0] {
    IDLE,
    RD_RE,
    RD_IM,
    CAP_IM,
    SEND,
    DONE
  } rd_state_e;

  // One extra copy of the sign bit turns a RAM word into a 3-byte sample.
  function automatic logic [SAMPLE_W-1:0] sext_sample(input logic [ND_FFT-1:0] v);
    return {v[ND_FFT-1], v};
  endfunction

endpackage

// File: rtl/fft_word_serializer.sv
// Sends a loaded 48-bit word as 6 bytes, MSB first, over a valid/ready byte link.
module fft_word_serializer
  import fft_rd_pkg::*;
(
  input  logic              clk_R,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_c
);

  logic [WORD_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;

  // Current byte is always the top of the shift register, so it is stable while stalled.
  assign tx_data = sh[WORD_W-1 -: 8];
  assign last_c  = tx_valid && tx_ready && (cnt == CNT_W'(BYTES_PER_BIN - 1));

  always_ff @(posedge clk_R) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sh       <= word;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (last_c) begin
        tx_valid <= 1'b0;
      end else begin
        sh  <= sh << 8;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fft_ram_reader.sv
// Walks FFT bins, reads Re/Im over the shared RAM read port and streams 6 bytes per bin.
module fft_ram_reader
  import fft_rd_pkg::*;
#(
  parameter int unsigned N_POINTS = N_DEPTH_FFT
) (
  input  logic              clk_R,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ReadEn_Re,
  output logic              ReadEn_Im,
  output logic [NA_FFT-1:0] Addr_R,
  input  logic [ND_FFT-1:0] ram_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [NA_FFT-1:0] K_LAST = NA_FFT'(N_POINTS - 1);

  rd_state_e         state;
  logic [NA_FFT-1:0] k;
  logic [ND_FFT-1:0] re_q;
  logic              load;
  logic              last_c;
  logic [WORD_W-1:0] word;

  assign Addr_R = k;
  assign load   = (state == CAP_IM);
  // Im[k] is on ram_data during CAP_IM, so it goes straight into the word.
  assign word   = {sext_sample(re_q), sext_sample(ram_data)};

  // Enables are set on entry to the state that owns them, so they line up with that state.
  always_ff @(posedge clk_R) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      re_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ReadEn_Re <= 1'b0;
      ReadEn_Im <= 1'b0;
    end else begin
      done      <= 1'b0;
      ReadEn_Re <= 1'b0;
      ReadEn_Im <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_RE;
            k         <= '0;
            busy      <= 1'b1;
            ReadEn_Re <= 1'b1;
          end
        end
        RD_RE: begin
          state     <= RD_IM;
          ReadEn_Im <= 1'b1;
        end
        RD_IM: begin
          re_q  <= ram_data;
          state <= CAP_IM;
        end
        CAP_IM: state <= SEND;
        SEND: begin
          if (last_c) begin
            if (k == K_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              k         <= k + NA_FFT'(1);
              state     <= RD_RE;
              ReadEn_Re <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          k     <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          k     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fft_word_serializer u_ser (
    .clk_R    (clk_R),
    .rst      (rst),
    .load     (load),
    .word     (word),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .last_c   (last_c)
  );

endmodule

// File: tb/tb_fft_ram_reader.sv
// Directed bench for fft_ram_reader with a 4-bin RAM model and a byte-capturing host.
module tb_fft_ram_reader;
  import fft_rd_pkg::*;

  localparam int unsigned NP = 4;

  logic              clk_R = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              ReadEn_Re;
  logic              ReadEn_Im;
  logic [NA_FFT-1:0] Addr_R;
  logic [ND_FFT-1:0] ram_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  logic [ND_FFT-1:0] re_mem [0:NP-1];
  logic [ND_FFT-1:0] im_mem [0:NP-1];

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q [$];
  int   first_valid, done_cnt, done_cyc, stall_bad, stalled_total, overlap_cnt;
  logic [NA_FFT-1:0] addr1;
  logic ren1, busy_end;

  always #5 clk_R = ~clk_R;

  fft_ram_reader #(.N_POINTS(NP)) dut (
    .clk_R     (clk_R),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ReadEn_Re (ReadEn_Re),
    .ReadEn_Im (ReadEn_Im),
    .Addr_R    (Addr_R),
    .ram_data  (ram_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // RAM read port: data valid the cycle after the enable.
  always @(posedge clk_R) begin
    if (ReadEn_Re)      ram_data <= re_mem[Addr_R[1:0]];
    else if (ReadEn_Im) ram_data <= im_mem[Addr_R[1:0]];
  end

  always @(negedge clk_R)
    assert (!(ReadEn_Re && ReadEn_Im)) else $error("FAIL en_overlap Re and Im both high");

  function automatic logic [7:0] exp_byte(input int idx);
    logic [47:0] w;
    int kk, bb;
    kk = idx / 6;
    bb = idx % 6;
    w  = {re_mem[kk][22], re_mem[kk], im_mem[kk][22], im_mem[kk]};
    return w[(47 - 8*bb) -: 8];
  endfunction

  task automatic start_frame();
    @(negedge clk_R);
    start = 1'b1;
    @(posedge clk_R);
    #1 start = 1'b0;
  endtask

  // Runs one readout after start_frame, logging bytes and event cycles (cycle 1 = RD_RE).
  task automatic capture(input int stall_byte, input int stall_len, input bit spurious,
                         input int max_cyc);
    int cyc, stalled, post;
    logic [7:0] held;
    cyc = 0; stalled = 0; post = -1; held = 8'h00;
    byte_q.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; stall_bad = 0; overlap_cnt = 0;
    while (cyc < max_cyc && post != 0) begin
      @(negedge clk_R);
      cyc++;
      start = 1'b0;
      if (post > 0) post--;
      if (cyc == 1) begin addr1 = Addr_R; ren1 = ReadEn_Re; end
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (ReadEn_Re && ReadEn_Im) overlap_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (post < 0) post = 3;
        if (spurious) start = 1'b1;
      end
      if (spurious && cyc == 5) start = 1'b1;
      if (tx_valid && byte_q.size() == stall_byte && stalled < stall_len) begin
        if (stalled == 0) held = tx_data;
        else if (tx_data !== held || Addr_R !== 8'd1 || ReadEn_Re || ReadEn_Im) stall_bad++;
        tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) byte_q.push_back(tx_data);
    end
    stalled_total = stalled;
    busy_end = busy;
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk_R);
    @(negedge clk_R);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (ReadEn_Re !== 1'b0) begin errors++; $display("FAIL rst_ren_re got %b want 0", ReadEn_Re); end
    checks++; if (ReadEn_Im !== 1'b0) begin errors++; $display("FAIL rst_ren_im got %b want 0", ReadEn_Im); end
    checks++; if (Addr_R !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", Addr_R); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    bad = 0;
    repeat (20) begin
      @(negedge clk_R);
      if ({busy, done, ReadEn_Re, ReadEn_Im, tx_valid} !== 5'b0 || Addr_R !== 8'h00 ||
          tx_data !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_idle20 got %0d bad cycles want 0", bad); end
  endtask

  task automatic check_stream(input string name, input int want_done_cyc);
    int bad;
    bad = 0;
    for (int i = 0; i < 24; i++)
      if (i >= byte_q.size() || byte_q[i] !== exp_byte(i)) bad++;
    checks++; if (byte_q.size() != 24) begin errors++; $display("FAIL %s_count got %0d want 24", name, byte_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_bytes got %0d wrong want 0", name, bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_cnt got %0d want 1", name, done_cnt); end
    checks++; if (done_cyc != want_done_cyc) begin errors++; $display("FAIL %s_done_cyc got %0d want %0d", name, done_cyc, want_done_cyc); end
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL %s_overlap got %0d want 0", name, overlap_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] b0 [0:5];
    b0 = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
    start_frame();
    capture(-1, 0, 1'b0, 200);
    checks++; if (first_valid != 4) begin errors++; $display("FAIL basic_first_valid got %0d want 4", first_valid); end
    checks++; if (addr1 !== 8'h00 || ren1 !== 1'b1) begin errors++; $display("FAIL basic_cyc1 got addr %h en %b want 00 1", addr1, ren1); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= byte_q.size() || byte_q[i] !== b0[i]) begin
        errors++;
        $display("FAIL basic_bin0_b%0d got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, b0[i]);
      end
    end
    check_stream("basic", 37);
  endtask

  task automatic test_backpressure();
    start_frame();
    capture(7, 10, 1'b0, 200);
    checks++; if (stalled_total != 10) begin errors++; $display("FAIL bp_stalled got %0d want 10", stalled_total); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", stall_bad); end
    check_stream("bp", 47);
  endtask

  task automatic test_spurious_start();
    start_frame();
    capture(-1, 0, 1'b1, 200);
    check_stream("spur", 37);
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL spur_busy_after got %b want 0", busy_end); end
  endtask

  task automatic test_abort();
    int dn;
    start_frame();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_R);
      tx_ready = 1'b1;
    end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got %b want 1", tx_valid); end
    rst = 1'b1;
    @(negedge clk_R);
    rst = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (Addr_R !== 8'h00 || tx_data !== 8'h00) begin errors++; $display("FAIL abort_outs got addr %h data %h want 00 00", Addr_R, tx_data); end
    dn = (done === 1'b1) ? 1 : 0;
    repeat (20) begin
      @(negedge clk_R);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_quiet got %0d done/busy cycles want 0", dn); end
    start_frame();
    capture(-1, 0, 1'b0, 200);
    checks++; if (addr1 !== 8'h00 || ren1 !== 1'b1) begin errors++; $display("FAIL abort_restart got addr %h en %b want 00 1", addr1, ren1); end
    check_stream("restart", 37);
  endtask

  task automatic test_sign_ext();
    logic [7:0] want [0:5];
    want = '{8'hC0, 8'h00, 8'h00, 8'h3F, 8'hFF, 8'hFF};
    re_mem[0] = 23'h400000;
    im_mem[0] = 23'h3FFFFF;
    start_frame();
    capture(-1, 0, 1'b0, 200);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= byte_q.size() || byte_q[i] !== want[i]) begin
        errors++;
        $display("FAIL sext_b%0d got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, want[i]);
      end
    end
    check_stream("sext", 37);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      re_mem[i] = 23'(i + 1);
      im_mem[i] = 23'h7FFFFF;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious_start();
    test_abort();
    test_sign_ext();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_ram_reader.md
Name: fft_ram_reader

Overview:
Read-side sequencer for the dual-port FFT result RAM. On a start pulse it walks bins 0..N_POINTS-1. For each bin it:
- reads the real part, then the imaginary part, over the RAM's shared 1-cycle-latency read port;
- sign-extends each 23-bit value to 24 bits;
- streams the 6 resulting bytes to the host link through a valid/ready byte interface.
It sits between RAM_FFT and the host UART transmitter of the electrochemical workstation.

Parameters:
ND_FFT, 23, data width of one RAM word (real or imaginary).
NA_FFT, 8, RAM address width.
N_POINTS, 256, number of bins read per run; legal range 1..2^NA_FFT.

Ports:
clk_R  in  1  read-side clock, same clock as the RAM read port.
rst  in  1  reset; one clock; reset is synchronous and active-high.
start  in  1  single-cycle request to begin a readout.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the last byte of the last bin has been accepted.
ReadEn_Re  out  1  RAM real-part read enable.
ReadEn_Im  out  1  RAM imaginary-part read enable.
Addr_R  out  NA_FFT  RAM read address (current bin index k).
ram_data  in  ND_FFT  RAM Data_O; valid 1 cycle after the enable.
tx_data  out  8  byte to transmitter.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  transmitter accepts; a transfer occurs on an edge where tx_valid && tx_ready.

Behaviour:
- Reset: state IDLE, k=0. All outputs 0: busy, done, ReadEn_Re, ReadEn_Im, Addr_R, tx_data, tx_valid.
- State IDLE: start sampled high -> RD_RE, k=0. Otherwise stay.
- State RD_RE: ReadEn_Re=1, Addr_R=k -> RD_IM.
- State RD_IM: ReadEn_Im=1, Addr_R=k. ram_data now holds Re[k] and is captured into re_q -> CAP_IM.
- State CAP_IM: both enables 0. ram_data now holds Im[k] and is captured into im_q. The 6-byte word is loaded -> SEND.
- State SEND: emits 6 bytes, one per accepted transfer, in this order:
  - {re_q[22],re_q[22:16]}, re_q[15:8], re_q[7:0]
  - {im_q[22],im_q[22:16]}, im_q[15:8], im_q[7:0]
- SEND exit: after the 6th transfer, k==N_POINTS-1 -> DONE; otherwise k<=k+1 -> RD_RE.
- State DONE: done=1 for exactly one cycle, then IDLE with k and Addr_R back to 0.
- Handshake:
  - tx_valid may rise regardless of tx_ready.
  - Once raised, tx_valid and tx_data hold stable until the transfer.
  - tx_valid drops only in the cycle after the 6th transfer.
  - Byte-to-byte transfers are back-to-back when tx_ready stays high.
- Latency: start edge = cycle 0. RD_RE is cycle 1 and the first tx_valid appears in cycle 4. With tx_ready held high, bin k occupies cycles 9k+1..9k+9 and done is asserted in cycle 9*N_POINTS+1.
- Backpressure: Addr_R stays at k from RD_RE through SEND, and no RAM enable is asserted in SEND.
- ReadEn_Re and ReadEn_Im are never high in the same cycle.
- start while busy (including the DONE cycle) is ignored. No queuing.
- rst mid-operation aborts immediately: the next cycle is IDLE with all outputs 0, no done pulse, and any partial bytes are discarded.
- The write side of the RAM must not be written during a run. This block does not check for it.

Decomposition:
- Shared package fft_rd_pkg holds:
  - ND_FFT, NA_FFT, N_DEPTH_FFT constants;
  - the state enum (IDLE, RD_RE, RD_IM, CAP_IM, SEND, DONE);
  - BYTES_PER_BIN=6.
- One sub-module, fft_word_serializer:
  - input side: 48-bit load port, load strobe;
  - output side: emits 6 bytes MSB-first over valid/ready and reports "last byte accepted".
- The FSM and address counter stay in fft_ram_reader.

Test Plan:
1. Reset check: assert rst 3 cycles, no start -> all outputs 0 and busy 0 for 20 cycles.
2. Basic readout: N_POINTS=4, RAM model Re[k]=k+1, Im[k]=23'h7FFFFF, tx_ready=1 -> 24 bytes, bin0 = 00 00 01 FF FF FF, first tx_valid in cycle 4, done in cycle 37 only.
3. Sign extension: Re[0]=23'h400000, Im[0]=23'h3FFFFF -> bytes C0 00 00 3F FF FF.
4. Backpressure: hold tx_ready=0 for 10 cycles during byte 2 of bin 1 -> tx_data stable, Addr_R=1 constant, no enable pulses, no byte lost or duplicated.
5. Spurious start: pulse start again in cycle 5 and in the DONE cycle -> ignored, exactly one done, 24 bytes total.
6. Abort: rst in cycle 15 (mid SEND of bin 1) -> tx_valid=0 and busy=0 next cycle, no done. A following start restarts at Addr_R=0, and ReadEn_Re&&ReadEn_Im is never true (assertion).
